edge_detector_bank: RTL and testbench

Parametrised multi-channel edge detector, successor to the single-channel edge detector. Per channel: input synchroniser, optional glitch filter, registered posedge/negedge/edge pulses, a per-channel mode that qualifies which edges count as events, a sticky event flag and a saturating edge counter. It sits between asynchronous pins (keys, external clocks, bus strobes) and the PSG control logic, which consumes either the pulses or the pending/count state.

---
 rtl/edge_detector_bank.sv | 240 ++++++++++++++++++++++++
 tb/tb_edge_detector_bank.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detector_bank.sv
`default_nettype none
// ============================================================================
// Module   : edge_detector_bank
// Purpose  : Multi-channel edge detector for asynchronous pins. Each channel
//            synchronises its raw input, optionally glitch-filters it, and
//            produces registered rise/fall/any-edge pulses, a sticky
//            mode-qualified event flag and a saturating edge counter.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Build option:
//   EDGE_GLITCH_FILTER_EN  defined   -> a new level must be seen on
//                                       FILTER_CYCLES consecutive synced
//                                       samples before it is accepted.
//                          undefined -> no filter counters; the first
//                                       differing sample is accepted
//                                       (FILTER_CYCLES behaves as 1).
// ----------------------------------------------------------------------------
// Parameters:
//   CHANNELS       number of independent channels (1..32)
//   SYNC_STAGES    synchroniser depth per channel (>=1)
//   FILTER_CYCLES  consecutive samples needed to accept a level (1..255)
//   CNT_WIDTH      width of each per-channel edge counter (>=1)
// Ports:
//   clk             single clock, all state on the rising edge
//   rst_n           asynchronous active-low reset
//   signal_i        raw asynchronous inputs, one bit per channel
//   mode_i          per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clear_i         per-channel synchronous clear of pending flag and count
//   level_o         accepted (filtered) level
//   on_posedge_o    one-cycle pulse on an accepted 0->1
//   on_negedge_o    one-cycle pulse on an accepted 1->0
//   on_edge_o       one-cycle pulse on either accepted edge
//   event_pending_o sticky flag set by a mode-qualified edge
//   edge_count_o    channel i at [CNT_WIDTH*i +: CNT_WIDTH], saturating
// ============================================================================
module edge_detector_bank #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHANNELS-1:0]           signal_i,
  input  logic [2*CHANNELS-1:0]         mode_i,
  input  logic [CHANNELS-1:0]           clear_i,
  output logic [CHANNELS-1:0]           level_o,
  output logic [CHANNELS-1:0]           on_posedge_o,
  output logic [CHANNELS-1:0]           on_negedge_o,
  output logic [CHANNELS-1:0]           on_edge_o,
  output logic [CHANNELS-1:0]           event_pending_o,
  output logic [CHANNELS*CNT_WIDTH-1:0] edge_count_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                     FILL_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [FILL_W-1:0]      FILL_DONE = FILL_W'(SYNC_STAGES);
  localparam logic [FILL_W-1:0]      FILL_ONE  = FILL_W'(1);
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);

`ifdef EDGE_GLITCH_FILTER_EN
  // The filter counter never needs to hold FILTER_CYCLES itself: acceptance
  // happens on the edge where it would have reached that value.
  localparam int                     FCW       = $clog2(FILTER_CYCLES + 1);
  localparam logic [FCW-1:0]         FILT_LAST = FCW'(FILTER_CYCLES - 1);
  localparam logic [FCW-1:0]         FILT_ONE  = FCW'(1);
`endif

  // --------------------------------------------------------------------------
  // Input synchroniser, shared storage for all channels.
  // sync_q[0] is the metastability-catching stage; the last stage is the
  // sample seen by the acceptance logic.
  // --------------------------------------------------------------------------
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] synced;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= signal_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Fill counter. After reset the synchroniser still holds reset zeros, which
  // must not be mistaken for a real low input. Samples are trusted only once
  // SYNC_STAGES edges have passed since release, so the first trusted sample
  // is the pin value captured on the first edge after release.
  // --------------------------------------------------------------------------
  logic [FILL_W-1:0] fill_q;
  logic              fill_done;

  assign fill_done = (fill_q == FILL_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
    end else if (!fill_done) begin
      fill_q <= fill_q + FILL_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel acceptance, pulses and event bookkeeping
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic                 smp;        // trusted synchronised sample
    logic                 accept;     // a new level is accepted this cycle
    logic                 qualified;  // accepted edge enabled by mode
    logic                 level_q;
    logic                 primed_q;   // a first level has been accepted
    logic                 pos_q;
    logic                 neg_q;
    logic                 edge_q;
    logic                 pend_q;
    logic                 pend_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    assign smp = synced[i];

`ifdef EDGE_GLITCH_FILTER_EN
    // fcnt_q has two meanings depending on primed_q:
    //   primed   : consecutive samples differing from level_q
    //   unprimed : length of the current run of identical samples
    // prev_q is only consulted while unprimed to detect a broken run.
    logic [FCW-1:0] fcnt_q;
    logic [FCW-1:0] fcnt_d;
    logic           prev_q;
    logic           run_cont;

    always_comb begin
      accept   = 1'b0;
      fcnt_d   = fcnt_q;
      run_cont = 1'b0;
      if (fill_done) begin
        if (primed_q) begin
          if (smp == level_q) begin
            fcnt_d = '0;
          end else if (fcnt_q == FILT_LAST) begin
            accept = 1'b1;
            fcnt_d = '0;
          end else begin
            fcnt_d = fcnt_q + FILT_ONE;
          end
        end else begin
          // A zero count means no trusted sample has been seen yet, so the
          // current sample starts a fresh run of length one.
          run_cont = (fcnt_q != '0) && (smp == prev_q);
          if (run_cont ? (fcnt_q == FILT_LAST) : (FILTER_CYCLES == 1)) begin
            accept = 1'b1;
            fcnt_d = '0;
          end else if (run_cont) begin
            fcnt_d = fcnt_q + FILT_ONE;
          end else begin
            fcnt_d = FILT_ONE;
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fcnt_q <= '0;
        prev_q <= 1'b0;
      end else begin
        fcnt_q <= fcnt_d;
        prev_q <= smp;
      end
    end
`else
    // Unfiltered: the first trusted sample primes the channel, afterwards
    // every differing sample is an edge.
    assign accept = fill_done && (!primed_q || (smp != level_q));
`endif

    // On acceptance the sample becomes the new level. For a primed channel
    // it necessarily differs from the old level; for the priming acceptance
    // the edge polarity is simply the sampled value, so both cases reduce
    // to the same pulse rule.
    assign qualified = accept && (smp ? mode_i[2*i] : mode_i[2*i+1]);

    // A clear coinciding with a qualified edge keeps that edge.
    always_comb begin
      pend_d = pend_q;
      cnt_d  = cnt_q;
      if (clear_i[i]) begin
        pend_d = qualified;
        cnt_d  = qualified ? CNT_ONE : '0;
      end else if (qualified) begin
        pend_d = 1'b1;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level_q  <= 1'b0;
        primed_q <= 1'b0;
        pos_q    <= 1'b0;
        neg_q    <= 1'b0;
        edge_q   <= 1'b0;
        pend_q   <= 1'b0;
        cnt_q    <= '0;
      end else begin
        pos_q  <= accept & smp;
        neg_q  <= accept & ~smp;
        edge_q <= accept;
        if (accept) begin
          level_q  <= smp;
          primed_q <= 1'b1;
        end
        pend_q <= pend_d;
        cnt_q  <= cnt_d;
      end
    end

    assign level_o[i]                             = level_q;
    assign on_posedge_o[i]                        = pos_q;
    assign on_negedge_o[i]                        = neg_q;
    assign on_edge_o[i]                           = edge_q;
    assign event_pending_o[i]                     = pend_q;
    assign edge_count_o[CNT_WIDTH*i +: CNT_WIDTH] = cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_edge_detector_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_detector_bank
// Purpose  : Self-checking bench for edge_detector_bank. A reference model
//            keeps the full history of pin values since reset release and
//            decides acceptance by inspecting windows of that history.
// Revision : 1.0  initial release
// ============================================================================
module tb_edge_detector_bank;

  localparam int CH   = 4;
  localparam int S    = 2;
  localparam int F    = 3;
  localparam int CW   = 2;
  localparam int MW   = 2 * CH;
  localparam int VW   = 5 * CH + CH * CW;
  localparam int CMAX = (1 << CW) - 1;
`ifdef EDGE_GLITCH_FILTER_EN
  localparam int FE   = F;
`else
  localparam int FE   = 1;
`endif
  // Edges from an input change (or reset release) to the pulse, counting
  // the first edge that sees the new value as edge 1.
  localparam int LAT  = S + FE;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [CH-1:0]       sig_r = '0;
  logic [MW-1:0]       mode_r = '0;
  logic [CH-1:0]       clear_r = '0;
  logic [CH-1:0]       level_o;
  logic [CH-1:0]       on_posedge_o;
  logic [CH-1:0]       on_negedge_o;
  logic [CH-1:0]       on_edge_o;
  logic [CH-1:0]       event_pending_o;
  logic [CH*CW-1:0]    edge_count_o;
  logic [VW-1:0]       act_vec;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  edge_detector_bank #(
    .CHANNELS      (CH),
    .SYNC_STAGES   (S),
    .FILTER_CYCLES (F),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .signal_i        (sig_r),
    .mode_i          (mode_r),
    .clear_i         (clear_r),
    .level_o         (level_o),
    .on_posedge_o    (on_posedge_o),
    .on_negedge_o    (on_negedge_o),
    .on_edge_o       (on_edge_o),
    .event_pending_o (event_pending_o),
    .edge_count_o    (edge_count_o)
  );

  assign act_vec = {level_o, on_posedge_o, on_negedge_o, on_edge_o,
                    event_pending_o, edge_count_o};

  // --------------------------------------------------------------------------
  // Reference model
  // hist[m-1] is the pin vector present at edge m after release. The trusted
  // sample at edge n is the pin value from edge n-S.
  // --------------------------------------------------------------------------
  logic [CH-1:0] hist [$];
  int            nedge;
  bit            m_level  [CH];
  bit            m_primed [CH];
  bit            m_pos    [CH];
  bit            m_neg    [CH];
  bit            m_pend   [CH];
  int            m_last   [CH];
  int            m_cnt    [CH];

  task automatic model_reset();
    hist.delete();
    nedge = 0;
    for (int c = 0; c < CH; c++) begin
      m_level[c] = 0; m_primed[c] = 0; m_pos[c] = 0; m_neg[c] = 0;
      m_pend[c]  = 0; m_last[c]   = 0; m_cnt[c] = 0;
    end
  endtask

  task automatic model_edge();
    nedge++;
    hist.push_back(sig_r);
    for (int c = 0; c < CH; c++) begin
      bit acc;
      bit val;
      bit q;
      int w;
      acc = 0;
      val = 0;
      // Window of the last FE trusted samples; for a primed channel it must
      // lie entirely after the previous acceptance.
      w = nedge - FE + 1;
      if ((w - S >= 1) && !(m_primed[c] && (w <= m_last[c]))) begin
        val = m_primed[c] ? !m_level[c] : hist[nedge-S-1][c];
        acc = 1;
        for (int k = w; k <= nedge; k++) begin
          if (hist[k-S-1][c] != val) acc = 0;
        end
      end
      m_pos[c] = acc && val;
      m_neg[c] = acc && !val;
      if (acc) begin
        m_level[c]  = val;
        m_primed[c] = 1;
        m_last[c]   = nedge;
      end
      q = acc && (val ? mode_r[2*c] : mode_r[2*c+1]);
      if (clear_r[c]) begin
        m_pend[c] = q;
        m_cnt[c]  = q ? 1 : 0;
      end else if (q) begin
        m_pend[c] = 1;
        if (m_cnt[c] < CMAX) m_cnt[c]++;
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [CH-1:0]    l, p, n, e, pd;
    logic [CH*CW-1:0] cn;
    for (int c = 0; c < CH; c++) begin
      l[c]  = m_level[c];
      p[c]  = m_pos[c];
      n[c]  = m_neg[c];
      e[c]  = m_pos[c] | m_neg[c];
      pd[c] = m_pend[c];
      cn[c*CW +: CW] = CW'(m_cnt[c]);
    end
    return {l, p, n, e, pd, cn};
  endfunction

  // One clock edge; the model follows the DUT, outputs are then sampled 1ns
  // after the edge. Inputs are changed by callers only after tick returns.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    #1;
  endtask

  task automatic do_reset(input logic [CH-1:0] s);
    #2 rst_n = 1'b0;
    model_reset();
    sig_r   = s;
    clear_r = '0;
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    model_reset();
    for (int t = 0; t < 3; t++) begin
      sig_r  = CH'($urandom);
      mode_r = MW'($urandom);
      tick();
      vectors++;
      if (act_vec !== '0) begin
        miscompares++;
        $display("FAIL reset_state: got %h expected 0", act_vec);
      end
    end
  endtask

  // ch0 high/rise, ch1 low/fall, ch2 low/both, ch3 random/off
  task automatic test_priming();
    mode_r = 8'b00_11_10_01;
    do_reset({1'($urandom), 1'b0, 1'b0, 1'b1});
    for (int t = 1; t <= LAT + 3; t++) begin
      tick();
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL priming t=%0d: got %h expected %h", t, act_vec, exp_vec());
      end
      if (t == LAT) begin
        vectors++;
        if (on_posedge_o[0] !== 1'b1 || on_negedge_o[1] !== 1'b1) begin
          miscompares++;
          $display("FAIL priming_pulse_edge: got pos0=%b neg1=%b expected 1 1",
                   on_posedge_o[0], on_negedge_o[1]);
        end
      end
    end
    vectors++;
    if ({level_o[0], event_pending_o[0], edge_count_o[0 +: CW], edge_count_o[CW +: CW]}
        !== {1'b1, 1'b1, 2'd1, 2'd1}) begin
      miscompares++;
      $display("FAIL priming_state: got lvl0=%b pend0=%b cnt0=%0d cnt1=%0d expected 1 1 1 1",
               level_o[0], event_pending_o[0], edge_count_o[0 +: CW], edge_count_o[CW +: CW]);
    end
  endtask

  // High glitches of 1..3 cycles on a low ch0
  task automatic test_glitch();
    sig_r[0] = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL glitch_settle: got %h expected %h", act_vec, exp_vec());
      end
    end
    for (int len = 1; len <= 3; len++) begin
      int pc;
      int nc;
      pc = 0;
      nc = 0;
      for (int t = 0; t < len + 12; t++) begin
        sig_r[0] = (t < len);
        tick();
        pc += int'(on_posedge_o[0]);
        nc += int'(on_negedge_o[0]);
        vectors++;
        if (act_vec !== exp_vec()) begin
          miscompares++;
          $display("FAIL glitch len=%0d t=%0d: got %h expected %h", len, t, act_vec, exp_vec());
        end
      end
      vectors++;
      if (pc !== ((len >= FE) ? 1 : 0) || nc !== ((len >= FE) ? 1 : 0) || level_o[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch_pulses len=%0d: got pos=%0d neg=%0d lvl=%b expected %0d %0d 0",
                 len, pc, nc, level_o[0], (len >= FE), (len >= FE));
      end
    end
  endtask

  // ch2 in mode 11: saturation, then clear colliding with an edge
  task automatic test_saturate();
    clear_r[2] = 1'b1;
    tick();
    clear_r[2] = 1'b0;
    for (int e = 0; e < 5; e++) begin
      sig_r[2] = ~sig_r[2];
      for (int t = 0; t < 8; t++) begin
        tick();
        vectors++;
        if (act_vec !== exp_vec()) begin
          miscompares++;
          $display("FAIL saturate e=%0d t=%0d: got %h expected %h", e, t, act_vec, exp_vec());
        end
      end
    end
    vectors++;
    if (edge_count_o[2*CW +: CW] !== 2'd3 || event_pending_o[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL saturate_count: got cnt=%0d pend=%b expected 3 1",
               edge_count_o[2*CW +: CW], event_pending_o[2]);
    end
    sig_r[2] = ~sig_r[2];
    for (int t = 1; t <= LAT; t++) begin
      clear_r[2] = (t == LAT);
      tick();
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL clear_collide t=%0d: got %h expected %h", t, act_vec, exp_vec());
      end
    end
    clear_r[2] = 1'b0;
    vectors++;
    if (edge_count_o[2*CW +: CW] !== 2'd1 || event_pending_o[2] !== 1'b1 || on_edge_o[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_with_edge: got cnt=%0d pend=%b edge=%b expected 1 1 1",
               edge_count_o[2*CW +: CW], event_pending_o[2], on_edge_o[2]);
    end
    repeat (4) tick();
    clear_r[2] = 1'b1;
    tick();
    clear_r[2] = 1'b0;
    vectors++;
    if (edge_count_o[2*CW +: CW] !== 2'd0 || event_pending_o[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_alone: got cnt=%0d pend=%b expected 0 0",
               edge_count_o[2*CW +: CW], event_pending_o[2]);
    end
  endtask

  // ch3: mode 00 keeps pulses alive but does not count; then mode 01
  task automatic test_mode_off();
    int ec;
    ec = 0;
    for (int e = 0; e < 8; e++) begin
      if (e == 4) mode_r[7:6] = 2'b01;
      sig_r[3] = ~sig_r[3];
      for (int t = 0; t < 8; t++) begin
        tick();
        if (e < 4) ec += int'(on_edge_o[3]);
        vectors++;
        if (act_vec !== exp_vec()) begin
          miscompares++;
          $display("FAIL mode e=%0d t=%0d: got %h expected %h", e, t, act_vec, exp_vec());
        end
      end
      if (e == 3) begin
        vectors++;
        if (ec !== 4 || edge_count_o[3*CW +: CW] !== 2'd0 || event_pending_o[3] !== 1'b0) begin
          miscompares++;
          $display("FAIL mode_off: got edges=%0d cnt=%0d pend=%b expected 4 0 0",
                   ec, edge_count_o[3*CW +: CW], event_pending_o[3]);
        end
      end
    end
    vectors++;
    if (edge_count_o[3*CW +: CW] !== 2'd2 || event_pending_o[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL mode_rise_only: got cnt=%0d pend=%b expected 2 1",
               edge_count_o[3*CW +: CW], event_pending_o[3]);
    end
  endtask

  task automatic test_midreset();
    sig_r[0] = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL midreset_pre t=%0d: got %h expected %h", t, act_vec, exp_vec());
      end
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (act_vec !== '0) begin
      miscompares++;
      $display("FAIL midreset_async: got %h expected 0", act_vec);
    end
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 1; t <= LAT + 2; t++) begin
      tick();
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL midreset_post t=%0d: got %h expected %h", t, act_vec, exp_vec());
      end
      if (t == LAT) begin
        vectors++;
        if (on_posedge_o[0] !== 1'b1) begin
          miscompares++;
          $display("FAIL midreset_reprime: got pos0=%b expected 1", on_posedge_o[0]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0) sig_r[c] = ~sig_r[c];
      end
      if ($urandom_range(0, 40) == 0) mode_r = MW'($urandom);
      clear_r = '0;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 15) == 0) clear_r[c] = 1'b1;
      end
      tick();
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL random t=%0d: got %h expected %h", t, act_vec, exp_vec());
      end
    end
    clear_r = '0;
  endtask

  initial begin
    test_reset();
    test_priming();
    test_glitch();
    test_saturate();
    test_mode_off();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
